order_packetizer: RTL and testbench

- Downstream stage of the strategy: consumes one decided order per handshake and serializes it into a fixed 28-byte order message.
- Output is an Avalon-ST stream with 8-byte beats, sop/eop/empty, for the MAC/egress path.
- Stamps each message with a 32-bit wrapping sequence number.
- Order capture overlaps the final beat, so back-to-back orders stream without bubbles.

---
 rtl/order_packetizer.sv | 122 ++++++++++++
 tb/tb_order_packetizer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/order_packetizer.sv
// order_packetizer: serializes one decided order per handshake into a fixed
// 28-byte message on an Avalon-ST stream of 8-byte beats, stamped with a
// wrapping 32-bit sequence number.
module order_packetizer #(
    parameter logic [7:0]  C_MSG_TYPE = 8'h4F,
    parameter logic [31:0] C_SEQ_INIT = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        order_valid,
    output logic        order_ready,
    input  logic        order_side,
    input  logic [63:0] order_symbol,
    input  logic [63:0] order_price,
    input  logic [31:0] order_volume,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_startofpacket,
    output logic        out_endofpacket,
    output logic [63:0] out_data,
    output logic [2:0]  out_empty,
    output logic        out_error,
    output logic [31:0] seq_next
);

    typedef enum logic [2:0] {
        IDLE,
        B0,
        B1,
        B2,
        B3
    } state_t;

    localparam logic [15:0] MSG_LEN   = 16'h001C;
    localparam logic [7:0]  SIDE_BUY  = 8'h42;
    localparam logic [7:0]  SIDE_SELL = 8'h53;

    state_t      state;
    logic [63:0] hold_symbol;
    logic [63:0] hold_price;
    logic [31:0] hold_volume;

    logic        beat_done;
    logic        accept;
    logic [31:0] seq_for_new;
    logic [7:0]  side_byte;

    assign out_error = 1'b0;

    // Handshake decode; order_ready is combinational from out_ready so a new
    // order can be captured in the same cycle as the final beat.
    always_comb begin
        beat_done   = out_valid & out_ready;
        order_ready = ~reset & ((state == IDLE) | ((state == B3) & out_ready));
        accept      = order_valid & order_ready;
        // An order captured alongside the final beat must carry the number
        // that seq_next is about to advance to.
        seq_for_new = ((state == B3) && beat_done) ? seq_next + 32'd1 : seq_next;
        side_byte   = order_side ? SIDE_SELL : SIDE_BUY;
    end

    // Beat sequencer: captures orders, builds each beat in the output
    // register one cycle ahead, and holds the beat while the sink stalls.
    // The B0 beat is built directly from the inputs at accept, so side and
    // seq need no separate holding copy: out_data itself retains them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            out_valid         <= 1'b0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            out_data          <= '0;
            out_empty         <= '0;
            seq_next          <= C_SEQ_INIT;
            hold_symbol       <= '0;
            hold_price        <= '0;
            hold_volume       <= '0;
        end else begin
            if ((state == B3) && beat_done) begin
                seq_next <= seq_next + 32'd1;
            end
            if (accept) begin
                hold_symbol       <= order_symbol;
                hold_price        <= order_price;
                hold_volume       <= order_volume;
                state             <= B0;
                out_valid         <= 1'b1;
                out_startofpacket <= 1'b1;
                out_endofpacket   <= 1'b0;
                out_empty         <= '0;
                out_data          <= {MSG_LEN, C_MSG_TYPE, side_byte, seq_for_new};
            end else begin
                case (state)
                    B0: if (beat_done) begin
                        state             <= B1;
                        out_startofpacket <= 1'b0;
                        out_data          <= hold_symbol;
                    end
                    B1: if (beat_done) begin
                        state    <= B2;
                        out_data <= hold_price;
                    end
                    B2: if (beat_done) begin
                        state           <= B3;
                        out_endofpacket <= 1'b1;
                        out_empty       <= 3'd4;
                        out_data        <= {hold_volume, 32'h0000_0000};
                    end
                    B3: if (beat_done) begin
                        state           <= IDLE;
                        out_valid       <= 1'b0;
                        out_endofpacket <= 1'b0;
                        out_empty       <= '0;
                        out_data        <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_order_packetizer.sv
// tb_order_packetizer: directed stimulus with a scoreboard. Expected beats are
// queued when an order is issued; a negedge monitor pops and compares them on
// every output handshake. Two instances run the same stimulus, one with the
// default initial sequence and one starting at FFFFFFFF to exercise the wrap.
module tb_order_packetizer;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
    } beat_t;

    localparam logic [31:0] INIT0 = 32'd0;
    localparam logic [31:0] INIT1 = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        order_valid;
    logic        order_side;
    logic [63:0] order_symbol;
    logic [63:0] order_price;
    logic [31:0] order_volume;
    logic        out_ready;

    logic [1:0]  order_ready;
    logic [1:0]  out_valid;
    logic [1:0]  sop;
    logic [1:0]  eop;
    logic [1:0]  err;
    logic [63:0] data [2];
    logic [2:0]  empty [2];
    logic [31:0] seq_next [2];

    int unsigned checks = 0;
    int unsigned passed = 0;

    beat_t       q0[$];
    beat_t       q1[$];
    logic [31:0] mseq0;
    logic [31:0] mseq1;

    logic        prev_stall [2];
    beat_t       prev_beat [2];
    logic        in_msg [2];
    int unsigned streak [2];
    int unsigned streak_max [2];
    int unsigned pops [2];
    beat_t       cur;
    beat_t       exp_b;

    always #5 clk = ~clk;

    order_packetizer u0 (
        .clk(clk), .reset(reset),
        .order_valid(order_valid), .order_ready(order_ready[0]),
        .order_side(order_side), .order_symbol(order_symbol),
        .order_price(order_price), .order_volume(order_volume),
        .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_startofpacket(sop[0]), .out_endofpacket(eop[0]),
        .out_data(data[0]), .out_empty(empty[0]), .out_error(err[0]),
        .seq_next(seq_next[0])
    );

    order_packetizer #(.C_SEQ_INIT(INIT1)) u1 (
        .clk(clk), .reset(reset),
        .order_valid(order_valid), .order_ready(order_ready[1]),
        .order_side(order_side), .order_symbol(order_symbol),
        .order_price(order_price), .order_volume(order_volume),
        .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_startofpacket(sop[1]), .out_endofpacket(eop[1]),
        .out_data(data[1]), .out_empty(empty[1]), .out_error(err[1]),
        .seq_next(seq_next[1])
    );

    task automatic check(input string name, input logic ok,
                         input logic [68:0] act, input logic [68:0] req);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    endtask

    // Queue the four expected beats for both instances.
    task automatic push(input logic s, input logic [63:0] sym,
                        input logic [63:0] pr, input logic [31:0] vol);
        logic [7:0] sb;
        sb = s ? 8'h53 : 8'h42;
        q0.push_back('{{16'h001C, 8'h4F, sb, mseq0}, 1'b1, 1'b0, 3'd0});
        q0.push_back('{sym, 1'b0, 1'b0, 3'd0});
        q0.push_back('{pr, 1'b0, 1'b0, 3'd0});
        q0.push_back('{{vol, 32'h0}, 1'b0, 1'b1, 3'd4});
        q1.push_back('{{16'h001C, 8'h4F, sb, mseq1}, 1'b1, 1'b0, 3'd0});
        q1.push_back('{sym, 1'b0, 1'b0, 3'd0});
        q1.push_back('{pr, 1'b0, 1'b0, 3'd0});
        q1.push_back('{{vol, 32'h0}, 1'b0, 1'b1, 3'd4});
        mseq0 = mseq0 + 32'd1;
        mseq1 = mseq1 + 32'd1;
    endtask

    // Present an order and wait (bounded) for it to be accepted; returns with
    // time at #1 after the accepting edge.
    task automatic send(input logic s, input logic [63:0] sym, input logic [63:0] pr,
                        input logic [31:0] vol, input logic keep, output int waits);
        order_valid  = 1'b1;
        order_side   = s;
        order_symbol = sym;
        order_price  = pr;
        order_volume = vol;
        push(s, sym, pr, vol);
        waits = 0;
        @(negedge clk);
        while (!order_ready[0] && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!order_ready[0]) check("accept_timeout", 1'b0, 69'(order_ready), 69'd1);
        @(posedge clk);
        #1;
        if (!keep) order_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("drained", q0.size() == 0 && q1.size() == 0,
              69'(q0.size() + q1.size()), 69'd0);
    endtask

    // Monitor: beat compare on handshake, stall stability, no mid-message drop.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            cur = {data[i], sop[i], eop[i], empty[i]};
            if (reset) begin
                prev_stall[i] = 1'b0;
                in_msg[i]     = 1'b0;
                streak[i]     = 0;
            end else begin
                if (prev_stall[i]) check("stall_hold", cur == prev_beat[i], cur, prev_beat[i]);
                if (in_msg[i]) check("valid_mid_msg", out_valid[i], 69'(out_valid[i]), 69'd1);
                if (out_valid[i] && out_ready) begin
                    if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                        check("beat_unexpected", 1'b0, cur, 69'd0);
                    end else begin
                        exp_b = (i == 0) ? q0.pop_front() : q1.pop_front();
                        check(i == 0 ? "beat_u0" : "beat_u1", cur == exp_b, cur, exp_b);
                        check("error_low", err[i] == 1'b0, 69'(err[i]), 69'd0);
                    end
                    pops[i]++;
                    streak[i]++;
                    if (streak[i] > streak_max[i]) streak_max[i] = streak[i];
                    in_msg[i] = !eop[i];
                end else begin
                    streak[i] = 0;
                end
                prev_stall[i] = out_valid[i] && !out_ready;
                prev_beat[i]  = cur;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int unsigned p0;
        for (int i = 0; i < 2; i++) begin
            prev_stall[i] = 1'b0;
            in_msg[i]     = 1'b0;
            streak[i]     = 0;
            streak_max[i] = 0;
            pops[i]       = 0;
        end
        mseq0        = INIT0;
        mseq1        = INIT1;
        reset        = 1'b1;
        order_valid  = 1'b0;
        order_side   = 1'b0;
        order_symbol = '0;
        order_price  = '0;
        order_volume = '0;
        out_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_outputs", {out_valid[i], sop[i], eop[i], empty[i], data[i], err[i]} == '0,
                  69'({out_valid[i], sop[i], eop[i], empty[i], data[i]}), 69'd0);
            check("rst_order_ready", order_ready[i] == 1'b0, 69'(order_ready[i]), 69'd0);
        end
        check("rst_seq_u0", seq_next[0] == INIT0, 69'(seq_next[0]), 69'(INIT0));
        check("rst_seq_u1", seq_next[1] == INIT1, 69'(seq_next[1]), 69'(INIT1));
        reset = 1'b0;

        // out_ready low in IDLE does not block acceptance
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("idle_ready", order_ready == 2'b11, 69'(order_ready), 69'd3);
        out_ready = 1'b1;

        // Single order
        send(1'b1, 64'h4142434400000000, 64'd10050, 32'd300, 1'b0, w);
        check("single_latency", out_valid[0] && sop[0], 69'({out_valid[0], sop[0]}), 69'd3);
        drain();
        check("seq_after_one_u0", seq_next[0] == 32'd1, 69'(seq_next[0]), 69'd1);
        check("seq_wrap_u1", seq_next[1] == 32'd0, 69'(seq_next[1]), 69'd0);

        // Back-to-back orders, order_valid held high
        streak_max[0] = 0;
        send(1'b0, 64'h4D53465400000000, 64'd999, 32'd5, 1'b1, w);
        send(1'b1, 64'h474F4F4700000000, 64'h0000_0001_0000_0000, 32'hDEAD_BEEF, 1'b0, w);
        check("b2b_ready_wait", w == 3, 69'(w), 69'd3);
        drain();
        check("b2b_no_bubble", streak_max[0] == 8, 69'(streak_max[0]), 69'd8);

        // Sink stall during B1: ready pattern 1,0,0,1
        p0 = pops[0];
        send(1'b0, 64'h1122334455667788, 64'h0102030405060708, 32'h0000_0064, 1'b0, w);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
        check("stall_beat_count", pops[0] - p0 == 4, 69'(pops[0] - p0), 69'd4);

        // Reset during B2 aborts the message
        send(1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 64'd7, 32'd8, 1'b0, w);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_valid", out_valid == 2'b00, 69'(out_valid), 69'd0);
        check("abort_ready", order_ready == 2'b00, 69'(order_ready), 69'd0);
        check("abort_seq_u0", seq_next[0] == INIT0, 69'(seq_next[0]), 69'(INIT0));
        check("abort_seq_u1", seq_next[1] == INIT1, 69'(seq_next[1]), 69'(INIT1));
        q0.delete();
        q1.delete();
        mseq0 = INIT0;
        mseq1 = INIT1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        send(1'b0, 64'h5359_4D42_4F4C_3031, 64'd12345, 32'd42, 1'b0, w);
        drain();

        // Inputs changed while the message is in flight
        send(1'b1, 64'h0F0E0D0C0B0A0908, 64'hFFFF_0000_FFFF_0000, 32'h1234_5678, 1'b0, w);
        for (int k = 0; k < 3; k++) begin
            order_side   = ~order_side;
            order_symbol = {$urandom, $urandom};
            order_price  = {$urandom, $urandom};
            order_volume = $urandom;
            @(posedge clk);
            #1;
        end
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
